// File: rtl/llc_req_if.sv
// Request/lookup/update/bus signal bundle for the LLC request sequencer.
// master = sequencer side, slave = front end, tag array and bus side.
interface llc_req_if #(
  parameter int ADDR_SIZE   = 32,
  parameter int OFFSET_SIZE = 6,
  parameter int INDEX_SIZE  = 14,
  parameter int N_WAY       = 8
);
  localparam int WAY_W = $clog2(N_WAY);
  localparam int TAG_W = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE;

  // cpu/snp: a request transfers on the cycle valid && ready are both high; ready is
  // only raised in IDLE, for at most one port, and valid must hold until then.
  logic                   cpu_valid;
  logic [1:0]             cpu_op;
  logic [ADDR_SIZE-1:0]   cpu_addr;
  logic                   cpu_ready;
  logic                   snp_valid;
  logic [1:0]             snp_op;
  logic [ADDR_SIZE-1:0]   snp_addr;
  logic                   snp_ready;
  logic                   lk_valid;
  logic [INDEX_SIZE-1:0]  lk_index;
  logic [TAG_W-1:0]       lk_tag;
  logic                   lk_hit;
  logic [WAY_W-1:0]       lk_way;
  logic [1:0]             lk_mesi;
  logic                   upd_valid;
  logic [WAY_W-1:0]       upd_way;
  logic [1:0]             upd_mesi;
  logic                   upd_touch;
  logic                   bus_valid;
  logic [2:0]             bus_op;
  logic [ADDR_SIZE-1:0]   bus_addr;
  logic                   bus_ack;
  logic                   bus_shared;
  logic [1:0]             snp_result;
  logic                   done;
  logic                   busy;

  modport master (
    input  cpu_valid, cpu_op, cpu_addr, snp_valid, snp_op, snp_addr,
    input  lk_hit, lk_way, lk_mesi, bus_ack, bus_shared,
    output cpu_ready, snp_ready, lk_valid, lk_index, lk_tag,
    output upd_valid, upd_way, upd_mesi, upd_touch,
    output bus_valid, bus_op, bus_addr, snp_result, done, busy
  );

  modport slave (
    output cpu_valid, cpu_op, cpu_addr, snp_valid, snp_op, snp_addr,
    output lk_hit, lk_way, lk_mesi, bus_ack, bus_shared,
    input  cpu_ready, snp_ready, lk_valid, lk_index, lk_tag,
    input  upd_valid, upd_way, upd_mesi, upd_touch,
    input  bus_valid, bus_op, bus_addr, snp_result, done, busy
  );
endinterface

// File: rtl/llc_req_ctrl.sv
// LLC request sequencer: arbitrates CPU vs snoop requests and walks each one through
// lookup, decision, optional evict/fill/invalidate bus traffic and the MESI/PLRU update.
module llc_req_ctrl #(
  parameter int ADDR_SIZE   = 32,
  parameter int OFFSET_SIZE = 6,
  parameter int INDEX_SIZE  = 14,
  parameter int N_WAY       = 8,
  parameter int STARVE_MAX  = 4
) (
  input  logic       clk,
  input  logic       rst,
  llc_req_if.master  io,
  output logic [2:0] dbg_state
);
  localparam int WAY_W  = $clog2(N_WAY);
  localparam int TAG_W  = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE;
  localparam int LINE_W = ADDR_SIZE - OFFSET_SIZE;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [1:0] CPU_WR = 2'd1, CPU_INV = 2'd2, SNP_RD = 2'd0;
  localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
  localparam logic [1:0] RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2;
  localparam logic [2:0] BUS_READ = 3'd1, BUS_WRITE = 3'd2, BUS_INV = 3'd3, BUS_RWIM = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_DECIDE, S_EVICT, S_FILL, S_INV, S_UPDATE, S_DONE
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    starve_cnt;
  logic                is_snp_q;
  logic [1:0]          op_q;
  logic [LINE_W-1:0]   line_q;
  logic [WAY_W-1:0]    way_q;
  logic [1:0]          mesi_q;
  logic                touch_q;
  logic [1:0]          result_q;
  logic                grant_cpu, grant_snp;
  logic                unused_offset;

  assign unused_offset = ^{io.cpu_addr[OFFSET_SIZE-1:0], io.snp_addr[OFFSET_SIZE-1:0]};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    grant_cpu = 1'b0;
    grant_snp = 1'b0;
    case (state)
      S_IDLE: begin
        // Snoops win unless the waiting CPU has already been passed over STARVE_MAX times.
        if (io.snp_valid && !(io.cpu_valid && starve_cnt == STARVE_LIM)) grant_snp = 1'b1;
        else if (io.cpu_valid)                                            grant_cpu = 1'b1;
        if (grant_snp || grant_cpu) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_DECIDE;
      S_DECIDE: begin
        if (is_snp_q || op_q == CPU_INV) state_d = io.lk_hit ? S_UPDATE : S_DONE;
        else if (io.lk_hit)
          state_d = (op_q == CPU_WR && io.lk_mesi == MESI_S) ? S_INV : S_UPDATE;
        else
          state_d = (io.lk_mesi == MESI_M) ? S_EVICT : S_FILL;
      end
      S_EVICT:        if (io.bus_ack) state_d = S_FILL;
      S_FILL, S_INV:  if (io.bus_ack) state_d = S_UPDATE;
      S_UPDATE:       state_d = S_DONE;
      S_DONE:         state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      is_snp_q   <= 1'b0;
      op_q       <= '0;
      line_q     <= '0;
      way_q      <= '0;
      mesi_q     <= MESI_I;
      touch_q    <= 1'b0;
      result_q   <= RES_NOHIT;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_snp) begin
            is_snp_q <= 1'b1;
            op_q     <= io.snp_op;
            line_q   <= io.snp_addr[ADDR_SIZE-1:OFFSET_SIZE];
            if (io.cpu_valid) starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_cpu) begin
            is_snp_q   <= 1'b0;
            op_q       <= io.cpu_op;
            line_q     <= io.cpu_addr[ADDR_SIZE-1:OFFSET_SIZE];
            starve_cnt <= '0;
          end
        end
        S_DECIDE: begin
          way_q    <= io.lk_way;
          result_q <= RES_NOHIT;
          if (is_snp_q) begin
            touch_q <= 1'b0;
            mesi_q  <= (op_q == SNP_RD && io.lk_mesi != MESI_I) ? MESI_S : MESI_I;
            if (io.lk_hit) result_q <= (io.lk_mesi == MESI_M) ? RES_HITM : RES_HIT;
          end else if (op_q == CPU_INV) begin
            touch_q <= 1'b0;
            mesi_q  <= MESI_I;
          end else begin
            touch_q <= 1'b1;
            mesi_q  <= (io.lk_hit && op_q != CPU_WR) ? io.lk_mesi : MESI_M;
          end
        end
        // A read fill learns its final state from the shared line on the ack cycle.
        S_FILL: if (io.bus_ack && op_q != CPU_WR) mesi_q <= io.bus_shared ? MESI_S : MESI_E;
        default: ;
      endcase
    end
  end

  always_comb begin
    io.cpu_ready  = grant_cpu && !rst;
    io.snp_ready  = grant_snp && !rst;
    io.lk_valid   = (state == S_LOOKUP);
    io.lk_index   = line_q[INDEX_SIZE-1:0];
    io.lk_tag     = line_q[LINE_W-1 -: TAG_W];
    io.upd_valid  = (state == S_UPDATE);
    io.upd_way    = (state == S_UPDATE || state == S_EVICT) ? way_q : '0;
    io.upd_mesi   = (state == S_UPDATE) ? mesi_q : MESI_I;
    io.upd_touch  = (state == S_UPDATE) && touch_q;
    io.bus_valid  = 1'b0;
    io.bus_op     = 3'd0;
    io.bus_addr   = '0;
    io.snp_result = (state == S_DONE) ? result_q : RES_NOHIT;
    io.done       = (state == S_DONE);
    io.busy       = (state != S_IDLE);
    case (state)
      S_EVICT: begin
        // The victim tag lives in the array, so only set index is placed on the bus.
        io.bus_valid = 1'b1;
        io.bus_op    = BUS_WRITE;
        io.bus_addr  = {{TAG_W{1'b0}}, line_q[INDEX_SIZE-1:0], {OFFSET_SIZE{1'b0}}};
      end
      S_FILL: begin
        io.bus_valid = 1'b1;
        io.bus_op    = (op_q == CPU_WR) ? BUS_RWIM : BUS_READ;
        io.bus_addr  = {line_q, {OFFSET_SIZE{1'b0}}};
      end
      S_INV: begin
        io.bus_valid = 1'b1;
        io.bus_op    = BUS_INV;
        io.bus_addr  = {line_q, {OFFSET_SIZE{1'b0}}};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_llc_req_ctrl.sv
// Directed bench for llc_req_ctrl: a transaction-level model predicts grants, lookups,
// bus transactions, updates and completion latency; a monitor compares every cycle.
module tb_llc_req_ctrl;
  localparam int AW = 32, OW = 6, IW = 14, NW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  llc_req_if #(.ADDR_SIZE(AW), .OFFSET_SIZE(OW), .INDEX_SIZE(IW), .N_WAY(NW)) io ();

  llc_req_ctrl #(.ADDR_SIZE(AW), .OFFSET_SIZE(OW), .INDEX_SIZE(IW), .N_WAY(NW),
                 .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .io(io), .dbg_state(dbg_state)
  );

  int checks = 0, errors = 0;
  int cyc = 0, grant_cyc = 0;
  int n_grant = 0, n_done = 0, n_upd = 0;
  int ack_delay = 1, m_starve = 0;
  bit auto_ack = 1'b1, man_ack = 1'b0;

  logic [34:0] exp_bus_q[$];
  logic [25:0] exp_lk_q[$];
  logic [5:0]  exp_upd_q[$];
  logic [9:0]  exp_done_q[$];
  logic        exp_grant_q[$];

  logic [2:0]  last_bus_op;
  logic [31:0] last_bus_addr, txn_first_addr;
  logic [5:0]  txn_bus_hist;
  int          txn_nbus, txn_nupd;
  logic [2:0]  last_upd_way;
  logic [1:0]  last_upd_mesi, last_result;
  logic        last_upd_touch;
  int          last_lat;
  string       gstr = "";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {io.cpu_ready, io.snp_ready, io.lk_valid, io.upd_valid, io.upd_way, io.upd_mesi,
            io.upd_touch, io.bus_valid, io.bus_op, io.snp_result, io.done, io.busy, io.bus_addr};
  endfunction

  // Transaction model: outcome derived from the request and the array/bus answers.
  function automatic void predict(input bit snp, input logic [1:0] op, input logic [31:0] addr,
                                  input bit hit, input logic [2:0] way, input logic [1:0] mesi,
                                  input bit shared, input int dly);
    logic [31:0] line;
    logic [1:0]  new_m, res;
    bit          do_upd, touch;
    int          lat;
    line   = {addr[31:6], 6'b0};
    res    = 2'd0;
    new_m  = 2'd0;
    touch  = 1'b0;
    do_upd = hit;
    lat    = 4;
    exp_grant_q.push_back(snp);
    exp_lk_q.push_back(addr[31:6]);
    if (snp) begin
      if (hit) begin
        new_m = (op == 2'd0 && mesi != 2'd0) ? 2'd1 : 2'd0;
        res   = (mesi == 2'd3) ? 2'd2 : 2'd1;
      end
    end else if (op == 2'd2) begin
      new_m = 2'd0;
    end else if (hit) begin
      touch = 1'b1;
      if (op == 2'd1) begin
        if (mesi == 2'd1) begin
          exp_bus_q.push_back({3'd3, line});
          lat += dly;
        end
        new_m = 2'd3;
      end else new_m = mesi;
    end else begin
      do_upd = 1'b1;
      touch  = 1'b1;
      if (mesi == 2'd3) begin
        exp_bus_q.push_back({3'd2, 12'd0, addr[19:6], 6'd0});
        lat += dly;
      end
      exp_bus_q.push_back({(op == 2'd1) ? 3'd4 : 3'd1, line});
      lat += dly;
      new_m = (op == 2'd1) ? 2'd3 : (shared ? 2'd1 : 2'd2);
    end
    if (do_upd) exp_upd_q.push_back({way, new_m, touch});
    else        lat = 3;
    exp_done_q.push_back({res, 8'(lat)});
  endfunction

  // Bus responder: acks after ack_delay cycles of each bus transaction.
  int bcnt = 0;
  bit ack_r = 1'b0;
  always @(negedge clk) begin
    if (ack_r) begin
      ack_r = 1'b0;
      bcnt  = 0;
    end
    if (io.bus_valid && !rst) begin
      bcnt++;
      if (bcnt == ack_delay) ack_r = 1'b1;
    end else bcnt = 0;
    io.bus_ack = auto_ack ? ack_r : man_ack;
  end

  logic        ack_at_edge = 1'b0;
  logic        bus_prev = 1'b0;
  logic [34:0] bus_hold = '0;
  always @(posedge clk) ack_at_edge <= io.bus_ack;

  // Monitor / scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (io.cpu_ready || io.snp_ready) begin
        check("one_grant", io.cpu_ready & io.snp_ready, 0);
        if (exp_grant_q.size() == 0) check("grant_unexpected", 1, 0);
        else check("grant_side", io.snp_ready, exp_grant_q.pop_front());
        grant_cyc    = cyc;
        txn_bus_hist = '0;
        txn_nbus     = 0;
        txn_nupd     = 0;
        n_grant++;
        gstr = io.snp_ready ? {gstr, "S"} : {gstr, "C"};
      end
      if (io.lk_valid) begin
        if (exp_lk_q.size() == 0) check("lk_unexpected", 1, 0);
        else check("lk_tag_index", {io.lk_tag, io.lk_index}, exp_lk_q.pop_front());
      end
      if (io.bus_valid && (!bus_prev || ack_at_edge)) begin
        if (exp_bus_q.size() == 0) check("bus_unexpected", {io.bus_op, io.bus_addr}, 0);
        else check("bus_op_addr", {io.bus_op, io.bus_addr}, exp_bus_q.pop_front());
        bus_hold      = {io.bus_op, io.bus_addr};
        last_bus_op   = io.bus_op;
        last_bus_addr = io.bus_addr;
        if (txn_nbus == 0) txn_first_addr = io.bus_addr;
        txn_bus_hist = {txn_bus_hist[2:0], io.bus_op};
        txn_nbus++;
      end else if (io.bus_valid) begin
        check("bus_stable", {io.bus_op, io.bus_addr}, bus_hold);
      end
      bus_prev = io.bus_valid;
      if (io.upd_valid) begin
        if (exp_upd_q.size() == 0) check("upd_unexpected", 1, 0);
        else check("upd_way_mesi_touch", {io.upd_way, io.upd_mesi, io.upd_touch},
                   exp_upd_q.pop_front());
        last_upd_way   = io.upd_way;
        last_upd_mesi  = io.upd_mesi;
        last_upd_touch = io.upd_touch;
        txn_nupd++;
        n_upd++;
      end
      if (io.done) begin
        last_lat    = cyc - grant_cyc;
        last_result = io.snp_result;
        if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_result_latency", {io.snp_result, 8'(last_lat)}, exp_done_q.pop_front());
        n_done++;
      end
    end else bus_prev = 1'b0;
  end

  task automatic run_txn(input bit snp, input logic [1:0] op, input logic [31:0] addr,
                         input bit hit, input logic [2:0] way, input logic [1:0] mesi,
                         input bit shared, input int dly);
    int n, target;
    predict(snp, op, addr, hit, way, mesi, shared, dly);
    if (!snp) m_starve = 0;
    io.lk_hit = hit; io.lk_way = way; io.lk_mesi = mesi;
    io.bus_shared = shared;
    ack_delay = dly;
    target = n_done + 1;
    if (snp) begin
      io.snp_valid = 1'b1; io.snp_op = op; io.snp_addr = addr;
    end else begin
      io.cpu_valid = 1'b1; io.cpu_op = op; io.cpu_addr = addr;
    end
    #1;
    n = 0;
    while (!(io.cpu_ready || io.snp_ready) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 20) check("grant_timeout", 1, 0);
    @(posedge clk); #1;
    io.cpu_valid = 1'b0;
    io.snp_valid = 1'b0;
    n = 0;
    while (n_done < target && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n_done < target) check("done_timeout", n_done, target);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nu, nd, g0, d0;
    io.cpu_valid = 0; io.cpu_op = 0; io.cpu_addr = 0;
    io.snp_valid = 0; io.snp_op = 0; io.snp_addr = 0;
    io.lk_hit = 0; io.lk_way = 0; io.lk_mesi = 0; io.bus_shared = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Read miss into invalid victim, 3-cycle bus wait, line not shared.
    run_txn(0, 2'd0, 32'h0000_1040, 0, 3'd0, 2'd0, 0, 3);
    check("t1_bus_op", last_bus_op, 3'd1);
    check("t1_bus_addr", last_bus_addr, 32'h0000_1040);
    check("t1_upd_mesi", last_upd_mesi, 2'd2);
    check("t1_upd_touch", last_upd_touch, 1);
    check("t1_latency", last_lat, 7);

    // Write hit on S needs a bus invalidate first; write hit on E does not.
    run_txn(0, 2'd1, 32'h0000_2080, 1, 3'd1, 2'd1, 0, 2);
    check("t2_bus_hist", txn_bus_hist, 6'o03);
    check("t2_upd_mesi", last_upd_mesi, 2'd3);
    run_txn(0, 2'd1, 32'h0000_3000, 1, 3'd3, 2'd2, 0, 2);
    check("t3_bus_count", txn_nbus, 0);
    check("t3_upd_mesi", last_upd_mesi, 2'd3);
    check("t3_latency", last_lat, 4);

    // Read miss over a modified victim in way 5, other cache shares the line.
    run_txn(0, 2'd0, 32'hABCD_1234, 0, 3'd5, 2'd3, 1, 2);
    check("t4_bus_hist", txn_bus_hist, 6'o21);
    check("t4_evict_addr", txn_first_addr, 32'h000D_1200);
    check("t4_upd_way", last_upd_way, 3'd5);
    check("t4_upd_mesi", last_upd_mesi, 2'd1);

    // Snoops: RWIM hit M, read hit E, invalidate miss.
    run_txn(1, 2'd1, 32'h0000_4000, 1, 3'd2, 2'd3, 0, 1);
    check("t5_result", last_result, 2'd2);
    check("t5_upd_mesi", last_upd_mesi, 2'd0);
    check("t5_upd_touch", last_upd_touch, 0);
    run_txn(1, 2'd0, 32'h0000_5040, 1, 3'd4, 2'd2, 0, 1);
    check("t6_result", last_result, 2'd1);
    check("t6_upd_mesi", last_upd_mesi, 2'd1);
    run_txn(1, 2'd2, 32'h0000_6000, 0, 3'd0, 2'd0, 0, 1);
    check("t7_result", last_result, 2'd0);
    check("t7_upd_count", txn_nupd, 0);

    // Both ports held valid: starvation limit forces a CPU grant after four snoops.
    gstr = "";
    io.lk_hit = 1; io.lk_way = 3'd7; io.lk_mesi = 2'd1; io.bus_shared = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_starve == 4) begin
        m_starve = 0;
        predict(0, 2'd0, 32'h0000_7000, 1, 3'd7, 2'd1, 0, 1);
      end else begin
        m_starve++;
        predict(1, 2'd0, 32'h0000_8000, 1, 3'd7, 2'd1, 0, 1);
      end
    end
    g0 = n_grant; d0 = n_done;
    io.cpu_op = 2'd0; io.cpu_addr = 32'h0000_7000; io.cpu_valid = 1;
    io.snp_op = 2'd0; io.snp_addr = 32'h0000_8000; io.snp_valid = 1;
    n = 0;
    while (n_grant < g0 + 10 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    io.cpu_valid = 0; io.snp_valid = 0;
    n = 0;
    while (n_done < d0 + 10 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("arb_done_count", n_done - d0, 10);
    checks++;
    if (gstr != "SSSSCSSSSC") begin
      errors++;
      $display("FAIL arb_order actual=%s expected=SSSSCSSSSC", gstr);
    end

    // Reset while waiting for a fill ack: transaction aborts, late ack is ignored.
    auto_ack = 1'b0;
    m_starve = 0;
    predict(0, 2'd0, 32'h0001_0080, 0, 3'd2, 2'd0, 0, 1);
    io.lk_hit = 0; io.lk_way = 3'd2; io.lk_mesi = 2'd0;
    io.cpu_op = 2'd0; io.cpu_addr = 32'h0001_0080; io.cpu_valid = 1;
    #1;
    n = 0;
    while (!io.cpu_ready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    @(posedge clk); #1;
    io.cpu_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pre_bus_valid", io.bus_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_outputs", out_vec(), 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    exp_upd_q.delete();
    exp_done_q.delete();
    check("rst_bus_consumed", exp_bus_q.size(), 0);
    nu = n_upd; nd = n_done;
    man_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    man_ack = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_upd", n_upd - nu, 0);
    check("rst_no_done", n_done - nd, 0);
    check("rst_idle", io.busy, 0);
    auto_ack = 1'b1;

    // Recovery: invalidate hit/miss and write miss.
    run_txn(0, 2'd2, 32'h0002_0000, 1, 3'd6, 2'd2, 0, 1);
    check("t10_upd_mesi", last_upd_mesi, 2'd0);
    check("t10_upd_touch", last_upd_touch, 0);
    run_txn(0, 2'd2, 32'h0002_1000, 0, 3'd1, 2'd1, 0, 1);
    check("t11_latency", last_lat, 3);
    run_txn(0, 2'd1, 32'h0003_0040, 0, 3'd4, 2'd1, 0, 1);
    check("t12_bus_op", last_bus_op, 3'd4);
    check("t12_upd_mesi", last_upd_mesi, 2'd3);

    repeat (3) @(posedge clk);
    check("leftover_exp", exp_bus_q.size() + exp_upd_q.size() + exp_done_q.size()
          + exp_grant_q.size() + exp_lk_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
